// File: rtl/pipeline_pkg.sv
//------------------------------------------------------------------------------
// pipeline_pkg : shared control-bundle bit map, width defaults, slot states
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pipeline_pkg;
   localparam int PKG_DATA_W     = 32;
   localparam int PKG_REG_ADDR_W = 5;
   localparam int PKG_CTRL_W     = 8;

   localparam int CTRL_MEM_READ   = 0;
   localparam int CTRL_MEM_WRITE  = 1;
   localparam int CTRL_REG_WR     = 2;
   localparam int CTRL_ALU_OP_LSB = 3;
   localparam int CTRL_ALU_OP_MSB = 7;

   localparam logic [PKG_CTRL_W-1:0] CTRL_BUBBLE = '0;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;
endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
//------------------------------------------------------------------------------
// hazard_detect : combinational load-use detection and upstream stall request
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hazard_detect
   import pipeline_pkg::*;
#(
   parameter int REG_ADDR_W = PKG_REG_ADDR_W
) (
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  ex_valid,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_ready,
   input  logic                  flush,
   output logic                  load_use,
   output logic                  stall_flag
);
   always_comb begin
      load_use   = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                   ((ex_rd == id_rs) | (ex_rd == id_rt));
      // A flush frees decode even when the slot is held or a hazard exists.
      stall_flag = ~flush & ((ex_valid & ~ex_ready) | load_use);
   end
endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
//------------------------------------------------------------------------------
// id_ex_stage : ID/EX pipeline register with load-use bubbles, WB bypass,
//               EX backpressure and flush. Optional stall counter: ID_EX_STALL_CNT_EN
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module id_ex_stage
   import pipeline_pkg::*;
#(
   parameter int DATA_W     = PKG_DATA_W,
   parameter int REG_ADDR_W = PKG_REG_ADDR_W,
   parameter int CTRL_W     = PKG_CTRL_W
`ifdef ID_EX_STALL_CNT_EN
   ,
   parameter int CNT_W      = 16
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [DATA_W-1:0]     id_pc,
   input  logic [CTRL_W-1:0]     id_ctrl,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [DATA_W-1:0]     id_imm,
   input  logic [DATA_W-1:0]     reg_file_rd_data1,
   input  logic [DATA_W-1:0]     reg_file_rd_data2,
   input  logic                  wb_reg_wr,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0]     wb_data,
   input  logic                  flush,
   input  logic                  ex_ready,
   output logic                  stall_flag,
   output logic                  ex_valid,
   output logic [DATA_W-1:0]     ex_pc,
   output logic [DATA_W-1:0]     ex_imm,
   output logic [CTRL_W-1:0]     ex_ctrl,
   output logic [REG_ADDR_W-1:0] ex_rs,
   output logic [REG_ADDR_W-1:0] ex_rt,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [DATA_W-1:0]     ex_op_a,
   output logic [DATA_W-1:0]     ex_op_b
`ifdef ID_EX_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0]      stall_cnt
`endif
);
   slot_state_t           state_q, state_d;
   logic [DATA_W-1:0]     pc_q, pc_d, imm_q, imm_d, op_a_q, op_a_d, op_b_q, op_b_d;
   logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
   logic [REG_ADDR_W-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
   logic                  w_load_use, w_hold, w_valid;
   logic [DATA_W-1:0]     w_op_a, w_op_b;

   assign w_valid = (state_q == SLOT_FULL);
   assign w_hold  = w_valid & ~ex_ready;

   hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_detect (
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .ex_valid    (w_valid),
      .ex_mem_read (ctrl_q[CTRL_MEM_READ]),
      .ex_rd       (rd_q),
      .ex_ready    (ex_ready),
      .flush       (flush),
      .load_use    (w_load_use),
      .stall_flag  (stall_flag)
   );

   // Register 0 is hard-wired, so a writeback to it never bypasses.
   assign w_op_a = (wb_reg_wr && wb_addr != '0 && wb_addr == id_rs) ? wb_data : reg_file_rd_data1;
   assign w_op_b = (wb_reg_wr && wb_addr != '0 && wb_addr == id_rt) ? wb_data : reg_file_rd_data2;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      imm_d   = imm_q;
      ctrl_d  = ctrl_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      rd_d    = rd_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      if (flush) begin
         state_d = SLOT_EMPTY;
         ctrl_d  = CTRL_W'(CTRL_BUBBLE);
      end else if (!w_hold) begin
         if (w_load_use) begin
            state_d = SLOT_EMPTY;
            ctrl_d  = CTRL_W'(CTRL_BUBBLE);
         end else begin
            state_d = id_valid ? SLOT_FULL : SLOT_EMPTY;
            pc_d    = id_pc;
            imm_d   = id_imm;
            ctrl_d  = id_ctrl;
            rs_d    = id_rs;
            rt_d    = id_rt;
            rd_d    = id_rd;
            op_a_d  = w_op_a;
            op_b_d  = w_op_b;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= SLOT_EMPTY;
         pc_q    <= '0;
         imm_q   <= '0;
         ctrl_q  <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         imm_q   <= imm_d;
         ctrl_q  <= ctrl_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         rd_q    <= rd_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
      end
   end

`ifdef ID_EX_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_flag && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

   assign ex_valid = w_valid;
   assign ex_pc    = pc_q;
   assign ex_imm   = imm_q;
   assign ex_ctrl  = ctrl_q;
   assign ex_rs    = rs_q;
   assign ex_rt    = rt_q;
   assign ex_rd    = rd_q;
   assign ex_op_a  = op_a_q;
   assign ex_op_b  = op_b_q;
endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
//------------------------------------------------------------------------------
// tb_id_ex_stage : directed self-checking bench for id_ex_stage
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_id_ex_stage;
   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   logic [31:0] id_pc, id_imm, reg_file_rd_data1, reg_file_rd_data2, wb_data;
   logic [7:0]  id_ctrl;
   logic [4:0]  id_rs, id_rt, id_rd, wb_addr;
   logic        wb_reg_wr, flush, ex_ready;
   logic        stall_flag, ex_valid;
   logic [31:0] ex_pc, ex_imm, ex_op_a, ex_op_b;
   logic [7:0]  ex_ctrl;
   logic [4:0]  ex_rs, ex_rt, ex_rd;
`ifdef ID_EX_STALL_CNT_EN
   logic [1:0]  stall_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   id_ex_stage #(
      .DATA_W(32), .REG_ADDR_W(5), .CTRL_W(8)
`ifdef ID_EX_STALL_CNT_EN
      , .CNT_W(2)
`endif
   ) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_ctrl(id_ctrl),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
      .reg_file_rd_data1(reg_file_rd_data1), .reg_file_rd_data2(reg_file_rd_data2),
      .wb_reg_wr(wb_reg_wr), .wb_addr(wb_addr), .wb_data(wb_data),
      .flush(flush), .ex_ready(ex_ready), .stall_flag(stall_flag), .ex_valid(ex_valid),
      .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_rd(ex_rd), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b)
`ifdef ID_EX_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 1'b1; id_valid = 1'b0; id_pc = '0; id_ctrl = '0; id_rs = '0; id_rt = '0;
      id_rd = '0; id_imm = '0; reg_file_rd_data1 = '0; reg_file_rd_data2 = '0;
      wb_reg_wr = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0; ex_ready = 1'b1;
   endtask

   task automatic present(input logic [31:0] pc, input logic [7:0] ctrl, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] imm,
                          input logic [31:0] d1, input logic [31:0] d2);
      id_valid = 1'b1; id_pc = pc; id_ctrl = ctrl; id_rs = rs; id_rt = rt; id_rd = rd;
      id_imm = imm; reg_file_rd_data1 = d1; reg_file_rd_data2 = d2;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         id_valid = 1'b1; id_pc = $urandom; id_ctrl = 8'h01; id_rs = 5'($urandom);
         id_rt = 5'($urandom); id_rd = 5'($urandom); id_imm = $urandom;
         reg_file_rd_data1 = $urandom; reg_file_rd_data2 = $urandom; ex_ready = 1'($urandom);
         step();
         n_checks++;
         if ({ex_valid, ex_pc, ex_imm, ex_ctrl, ex_rs, ex_rt, ex_rd, ex_op_a, ex_op_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%0b pc=%h ctrl=%h opa=%h opb=%h, want all zero",
                     ex_valid, ex_pc, ex_ctrl, ex_op_a, ex_op_b);
         end
         n_checks++;
         if (stall_flag !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %0b want 0", stall_flag);
         end
      end
`ifdef ID_EX_STALL_CNT_EN
      n_checks++;
      if (stall_cnt !== 2'd0) begin
         n_fail++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
      end
`endif
      idle();
      present(32'h100, 8'h0C, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0, 32'h0);
      step();
      n_checks++;
      if (ex_valid !== 1'b1 || ex_pc !== 32'h100) begin
         n_fail++; $display("FAIL reset_release: valid=%0b pc=%h want 1/00000100", ex_valid, ex_pc);
      end
      idle();
      step();
      n_checks++;
      if (ex_valid !== 1'b0) begin
         n_fail++; $display("FAIL empty_capture: valid=%0b want 0", ex_valid);
      end
   endtask

   task automatic test_add();
      idle();
      present(32'h200, 8'h0C, 5'd4, 5'd5, 5'd6, 32'h10, 32'd4, 32'd5);
      step();
      n_checks++;
      if (ex_valid !== 1'b1 || ex_op_a !== 32'd4 || ex_op_b !== 32'd5) begin
         n_fail++; $display("FAIL add_ops: valid=%0b a=%h b=%h want 1/4/5", ex_valid, ex_op_a, ex_op_b);
      end
      n_checks++;
      if (ex_rd !== 5'd6 || ex_rs !== 5'd4 || ex_rt !== 5'd5 || ex_ctrl !== 8'h0C ||
          ex_imm !== 32'h10 || ex_pc !== 32'h200) begin
         n_fail++; $display("FAIL add_fields: rd=%0d rs=%0d rt=%0d ctrl=%h imm=%h pc=%h want 6/4/5/0c/10/200",
                            ex_rd, ex_rs, ex_rt, ex_ctrl, ex_imm, ex_pc);
      end
      idle();
      step();
   endtask

   task automatic test_load_use();
      idle();
      present(32'h300, 8'h05, 5'd1, 5'd0, 5'd8, 32'h4, 32'h40, 32'h0);
      step();
      present(32'h304, 8'h0C, 5'd8, 5'd2, 5'd9, 32'h0, 32'h11, 32'h22);
      #1;
      n_checks++;
      if (stall_flag !== 1'b1) begin
         n_fail++; $display("FAIL lu_stall: got %0b want 1", stall_flag);
      end
      step();
      n_checks++;
      if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || stall_flag !== 1'b0) begin
         n_fail++; $display("FAIL lu_bubble: valid=%0b ctrl=%h stall=%0b want 0/00/0",
                            ex_valid, ex_ctrl, stall_flag);
      end
      step();
      n_checks++;
      if (ex_valid !== 1'b1 || ex_rd !== 5'd9 || ex_op_a !== 32'h11 || ex_op_b !== 32'h22) begin
         n_fail++; $display("FAIL lu_capture: valid=%0b rd=%0d a=%h b=%h want 1/9/11/22",
                            ex_valid, ex_rd, ex_op_a, ex_op_b);
      end
`ifdef ID_EX_STALL_CNT_EN
      n_checks++;
      if (stall_cnt !== 2'd1) begin
         n_fail++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt);
      end
`endif
      idle();
      step();
   endtask

   task automatic test_hold();
      idle();
      present(32'h400, 8'h0C, 5'd1, 5'd2, 5'd3, 32'h7, 32'hA, 32'hB);
      step();
      present(32'h404, 8'h0C, 5'd10, 5'd11, 5'd7, 32'h8, 32'hC, 32'hD);
      ex_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (stall_flag !== 1'b1) begin
            n_fail++; $display("FAIL hold_stall[%0d]: got %0b want 1", i, stall_flag);
         end
         step();
         n_checks++;
         if (ex_valid !== 1'b1 || ex_pc !== 32'h400 || ex_rd !== 5'd3 || ex_op_a !== 32'hA) begin
            n_fail++; $display("FAIL hold_stable[%0d]: valid=%0b pc=%h rd=%0d a=%h want 1/400/3/a",
                               i, ex_valid, ex_pc, ex_rd, ex_op_a);
         end
      end
      ex_ready = 1'b1;
      #1;
      n_checks++;
      if (stall_flag !== 1'b0) begin
         n_fail++; $display("FAIL hold_release: stall=%0b want 0", stall_flag);
      end
      step();
      n_checks++;
      if (ex_pc !== 32'h404 || ex_rd !== 5'd7) begin
         n_fail++; $display("FAIL hold_next: pc=%h rd=%0d want 404/7", ex_pc, ex_rd);
      end
`ifdef ID_EX_STALL_CNT_EN
      n_checks++;
      if (stall_cnt !== 2'd3) begin
         n_fail++; $display("FAIL cnt_saturate: got %0d want 3", stall_cnt);
      end
`endif
      idle();
      step();
   endtask

   task automatic test_bypass();
      idle();
      present(32'h500, 8'h0C, 5'd15, 5'd3, 5'd4, 32'h0, 32'h1111, 32'h2222);
      wb_reg_wr = 1'b1; wb_addr = 5'd15; wb_data = 32'hDEAD;
      step();
      n_checks++;
      if (ex_op_a !== 32'hDEAD || ex_op_b !== 32'h2222) begin
         n_fail++; $display("FAIL bypass_rs: a=%h b=%h want dead/2222", ex_op_a, ex_op_b);
      end
      present(32'h504, 8'h0C, 5'd0, 5'd15, 5'd4, 32'h0, 32'h0, 32'h3333);
      wb_addr = 5'd0;
      step();
      n_checks++;
      if (ex_op_a !== 32'h0 || ex_op_b !== 32'h3333) begin
         n_fail++; $display("FAIL bypass_r0: a=%h b=%h want 0/3333", ex_op_a, ex_op_b);
      end
      present(32'h508, 8'h0C, 5'd9, 5'd15, 5'd4, 32'h0, 32'h4444, 32'h5555);
      wb_reg_wr = 1'b1; wb_addr = 5'd15; wb_data = 32'hBEEF;
      step();
      n_checks++;
      if (ex_op_a !== 32'h4444 || ex_op_b !== 32'hBEEF) begin
         n_fail++; $display("FAIL bypass_rt: a=%h b=%h want 4444/beef", ex_op_a, ex_op_b);
      end
      present(32'h50C, 8'h0C, 5'd15, 5'd2, 5'd4, 32'h0, 32'h6666, 32'h7777);
      wb_reg_wr = 1'b0;
      step();
      n_checks++;
      if (ex_op_a !== 32'h6666) begin
         n_fail++; $display("FAIL bypass_nowr: a=%h want 6666", ex_op_a);
      end
      idle();
      step();
   endtask

   task automatic test_flush_reset();
      idle();
      present(32'h600, 8'h05, 5'd1, 5'd0, 5'd8, 32'h0, 32'h0, 32'h0);
      step();
      present(32'h604, 8'h0C, 5'd8, 5'd2, 5'd9, 32'h0, 32'h1, 32'h2);
      ex_ready = 1'b0; flush = 1'b1;
      #1;
      n_checks++;
      if (stall_flag !== 1'b0) begin
         n_fail++; $display("FAIL flush_stall: got %0b want 0", stall_flag);
      end
      step();
      flush = 1'b0;
      #1;
      n_checks++;
      if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || stall_flag !== 1'b0) begin
         n_fail++; $display("FAIL flush_kill: valid=%0b ctrl=%h stall=%0b want 0/00/0",
                            ex_valid, ex_ctrl, stall_flag);
      end
      idle();
      present(32'h700, 8'h0C, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0, 32'h0);
      step();
      ex_ready = 1'b0;
      #1;
      n_checks++;
      if (stall_flag !== 1'b1) begin
         n_fail++; $display("FAIL midstall_pre: stall=%0b want 1", stall_flag);
      end
      reset = 1'b0;
      step();
      n_checks++;
      if (ex_valid !== 1'b0 || stall_flag !== 1'b0 || ex_pc !== 32'h0) begin
         n_fail++; $display("FAIL midstall_reset: valid=%0b stall=%0b pc=%h want 0/0/0",
                            ex_valid, stall_flag, ex_pc);
      end
`ifdef ID_EX_STALL_CNT_EN
      n_checks++;
      if (stall_cnt !== 2'd0) begin
         n_fail++; $display("FAIL midstall_cnt: got %0d want 0", stall_cnt);
      end
`endif
      idle();
      step();
   endtask

   initial begin
      idle();
      test_reset();
      test_add();
      test_load_use();
      test_hold();
      test_bypass();
      test_flush_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
